pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Drives the enable/flush inputs of the pipeline registers and arbitrates the
//  single-ported cache between instruction fetch and the MEM-stage data access.
//  Consumes MEM-stage request flags and the WB-stage halt flag; produces gated
//  iREN/dREN/dWEN towards the cache, a sticky halt, a stall watchdog and perf counters.
// PARAMETERS
//  CNT_W    16  width of stall_cnt / flush_cnt (saturating)
//  TIMEOUT  0   max consecutive cycles in DMEM+RESUME before timeout; 0 = watchdog off
// PORTS
//  CLK        in   1      clock, all state updates on posedge
//  RST        in   1      synchronous reset, active-high
//  ihit       in   1      instruction cache hit / fetch done this cycle
//  dhit       in   1      data cache access done this cycle
//  dREN_m     in   1      MEM-stage load request (dREN_out_3)
//  dWEN_m     in   1      MEM-stage store request (dWEN_out_3)
//  redirect   in   1      MEM-stage taken branch / jump / JR, level, held by pipeline
//  halt_wb    in   1      WB-stage halt (halt_or_out_4)
//  enable     out  1      pipeline register enable
//  flush      out  1      pipeline register flush (only ever with enable=1)
//  iREN       out  1      instruction read request to cache
//  dREN       out  1      data read request to cache
//  dWEN       out  1      data write request to cache
//  halt       out  1      sticky processor halted
//  timeout    out  1      sticky watchdog error
//  stall_cnt  out  CNT_W  cycles with enable=0 in non-HALT states, saturating
//  flush_cnt  out  CNT_W  cycles with flush=1, saturating
// BEHAVIOUR
//  - States IFETCH, DMEM, RESUME, HALT; state/counters/sticky bits registered,
//    enable/flush/iREN/dREN/dWEN combinational from state + inputs (0 latency).
//  - RST=1: next state IFETCH, counters, wait counter, halt, timeout <= 0; while RST=1
//    all outputs forced 0 regardless of state.
//  - Priority: halt_wb=1 in any non-HALT state -> enable=flush=iREN=dREN=dWEN=0,
//    next=HALT (overrides every rule below).
//  - IFETCH: iREN=1. If dREN_m|dWEN_m: enable=0, next=DMEM (ihit ignored).
//    Else enable=ihit, flush=ihit&redirect, stay.
//  - DMEM: iREN=0, dREN=dREN_m, dWEN=dWEN_m, enable=0. dhit -> RESUME, else stay.
//  - RESUME: iREN=1, dREN=dWEN=0. ihit -> enable=1, flush=redirect, next=IFETCH;
//    else enable=0, stay. Redirect raised during a stall is honoured only here.
//  - HALT: all requests/enable/flush 0; halt=1; exits only via RST.
//  - halt register set on the cycle HALT is entered (visible the cycle after halt_wb).
//  - wait counter: increments each cycle in DMEM or RESUME, cleared on entering IFETCH;
//    TIMEOUT!=0 and count reaches TIMEOUT -> timeout<=1 sticky; FSM unaffected.
//  - stall_cnt +1 when enable=0 and state!=HALT and halt_wb=0; flush_cnt +1 when flush=1;
//    both saturate at all-ones, never wrap.
//  - dREN_m and dWEN_m both 1 is passed through unchanged; not checked here.
// TESTING
//  1. ihit=1 every cycle, no mem req, redirect pulse 1 cycle -> enable=1 each cycle,
//     flush=1 that cycle only, flush_cnt=1, stall_cnt=0.
//  2. IFETCH with dREN_m=1, ihit=1; dhit on 3rd DMEM cycle; ihit 1st RESUME cycle ->
//     enable 0,0,0,0 then 1; dREN=1 for 3 cycles only; stall_cnt=4.
//  3. redirect=1 during DMEM, dhit, RESUME ihit after 2 cycles -> flush=0 throughout
//     stall, flush=1 with enable=1 in RESUME ihit cycle only.
//  4. halt_wb=1 in DMEM -> dREN drops same cycle, halt=1 next cycle, stays 1 with
//     ihit/dhit toggling; enable stays 0; stall_cnt frozen.
//  5. TIMEOUT=8, dWEN_m=1, dhit never -> timeout=1 after 8th DMEM cycle, sticky;
//     later dhit still moves FSM to RESUME; RST clears timeout.
//  6. RST mid-DMEM -> outputs 0 during RST, next cycle IFETCH, iREN=1, counters 0;
//     CNT_W=4 stall of 20 cycles -> stall_cnt=15 (no wrap).

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Groups the signals between the pipeline controller, the pipeline stages
//   and the single-ported cache. The controller drives the cache request
//   strobes and the pipeline register controls.
//
//   master modport (controller side):
//     in  ihit      instruction fetch done this cycle
//     in  dhit      data access done this cycle
//     in  dREN_m    MEM-stage load request
//     in  dWEN_m    MEM-stage store request
//     in  redirect  MEM-stage taken branch / jump, level, held by pipeline
//     in  halt_wb   WB-stage halt
//     out enable    pipeline register enable
//     out flush     pipeline register flush (only ever with enable=1)
//     out iREN      instruction read request to cache
//     out dREN      data read request to cache
//     out dWEN      data write request to cache
//   slave modport: the same signals seen from the pipeline/cache side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic ihit;
  logic dhit;
  logic dREN_m;
  logic dWEN_m;
  logic redirect;
  logic halt_wb;
  logic enable;
  logic flush;
  logic iREN;
  logic dREN;
  logic dWEN;

  modport master (
    input  ihit, dhit, dREN_m, dWEN_m, redirect, halt_wb,
    output enable, flush, iREN, dREN, dWEN
  );

  modport slave (
    output ihit, dhit, dREN_m, dWEN_m, redirect, halt_wb,
    input  enable, flush, iREN, dREN, dWEN
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Drives enable/flush of the pipeline registers and arbitrates the
//   single-ported cache between instruction fetch and MEM-stage data access.
//   Also keeps a sticky halt, a stall watchdog and saturating perf counters.
//
//   Parameters:
//     CNT_W    width of stall_cnt / flush_cnt (saturating)
//     TIMEOUT  consecutive DMEM+RESUME cycles before timeout; 0 = off
//
//   Ports:
//     CLK        clock, all state updates on posedge
//     RST        synchronous reset, active-high; forces all outputs to 0
//     bus        pipeline_ctrl_if.master (requests in, controls out)
//     halt       sticky processor halted
//     timeout    sticky watchdog error
//     stall_cnt  cycles with enable=0 outside HALT, saturating
//     flush_cnt  cycles with flush=1, saturating
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic               CLK,
  input  logic               RST,
  pipeline_ctrl_if.master    bus,
  output logic               halt,
  output logic               timeout,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    IFETCH = 2'd0,
    DMEM   = 2'd1,
    RESUME = 2'd2,
    HALT   = 2'd3
  } state_t;

  // The wait counter only needs to reach TIMEOUT; with the watchdog off it
  // shrinks to a single unused bit.
  localparam int unsigned WAIT_MAX = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  state_t            state_q, state_d;
  logic              enable_c, flush_c, iren_c, dren_c, dwen_c;
  logic              halt_q, timeout_q;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  stall_q, flush_q;

  logic              in_wait;
  logic              stall_inc;
  logic              timeout_set;

  // -------------------------------------------------------------------------
  // Next state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    enable_c = 1'b0;
    flush_c  = 1'b0;
    iren_c   = 1'b0;
    dren_c   = 1'b0;
    dwen_c   = 1'b0;

    if (RST) begin
      state_d = IFETCH;
    end else if (state_q != HALT && bus.halt_wb) begin
      // A retiring halt beats every other rule: drop all requests now.
      state_d = HALT;
    end else begin
      unique case (state_q)
        IFETCH: begin
          iren_c = 1'b1;
          if (bus.dREN_m || bus.dWEN_m) begin
            // Data access owns the cache next; this cycle's ihit is dropped
            // and the fetch is repeated in RESUME.
            state_d = DMEM;
          end else begin
            enable_c = bus.ihit;
            flush_c  = bus.ihit & bus.redirect;
          end
        end
        DMEM: begin
          dren_c = bus.dREN_m;
          dwen_c = bus.dWEN_m;
          if (bus.dhit) state_d = RESUME;
        end
        RESUME: begin
          iren_c = 1'b1;
          if (bus.ihit) begin
            // A redirect raised while stalled only takes effect here, when
            // the pipeline actually advances.
            enable_c = 1'b1;
            flush_c  = bus.redirect;
            state_d  = IFETCH;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IFETCH;
        end
      endcase
    end
  end

  assign in_wait     = (state_q == DMEM) || (state_q == RESUME);
  assign stall_inc   = ~RST && ~enable_c && (state_q != HALT) && ~bus.halt_wb;
  // Set on the cycle the count steps onto TIMEOUT (or is already there).
  assign timeout_set = (TIMEOUT != 0) && in_wait && (wait_q >= WAIT_LIM - 1'b1);

  // -------------------------------------------------------------------------
  // State register, sticky bits, wait counter and perf counters
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IFETCH;
      halt_q    <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q != HALT && bus.halt_wb) halt_q <= 1'b1;

      if (timeout_set) timeout_q <= 1'b1;

      if (state_d == IFETCH) begin
        wait_q <= '0;
      end else if (in_wait && wait_q != WAIT_LIM) begin
        wait_q <= wait_q + 1'b1;
      end

      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_c   && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs; registered values are masked so everything reads 0 during RST.
  // -------------------------------------------------------------------------
  assign bus.enable = enable_c;
  assign bus.flush  = flush_c;
  assign bus.iREN   = iren_c;
  assign bus.dREN   = dren_c;
  assign bus.dWEN   = dwen_c;

  assign halt      = halt_q & ~RST;
  assign timeout   = timeout_q & ~RST;
  assign stall_cnt = RST ? '0 : stall_q;
  assign flush_cnt = RST ? '0 : flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Two controllers share one stimulus stream: dut_a with CNT_W=16 and the
//   watchdog off, dut_b with CNT_W=4 and TIMEOUT=8. A cycle-level reference
//   model produces the expected outputs for each driven cycle and pushes them
//   into a queue; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int TOUT_B = 8;

  typedef struct {
    bit en, fl, ir, dr, dw, hl, to_b;
    int stall, flush;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pipeline_ctrl_if ifa ();
  pipeline_ctrl_if ifb ();

  logic        halt_a, timeout_a, halt_b, timeout_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  pipeline_ctrl #(.CNT_W(16), .TIMEOUT(0)) dut_a (
    .CLK(CLK), .RST(RST), .bus(ifa),
    .halt(halt_a), .timeout(timeout_a), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  pipeline_ctrl #(.CNT_W(4), .TIMEOUT(TOUT_B)) dut_b (
    .CLK(CLK), .RST(RST), .bus(ifb),
    .halt(halt_b), .timeout(timeout_b), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // -------------------------------------------------------------------------
  // Reference model: where the controller is (fetching, waiting on data,
  // refetching, halted) plus plain integer counts.
  // -------------------------------------------------------------------------
  bit m_halted, m_mem, m_res, m_tout;
  int m_wait, m_stall, m_flush;

  task automatic model(input bit rst, ih, dh, dr, dw, rd, hw, output exp_t e);
    bit was_wait, was_halted;
    e = '{default: 0};
    if (rst) begin
      m_halted = 0; m_mem = 0; m_res = 0; m_tout = 0;
      m_wait = 0; m_stall = 0; m_flush = 0;
      return;
    end
    e.hl    = m_halted;
    e.to_b  = m_tout;
    e.stall = m_stall;
    e.flush = m_flush;
    was_wait   = m_mem || m_res;
    was_halted = m_halted;

    if (m_halted) begin
      // nothing issued
    end else if (hw) begin
      m_halted = 1; m_mem = 0; m_res = 0;
    end else if (m_mem) begin
      e.dr = dr; e.dw = dw;
      if (dh) begin m_mem = 0; m_res = 1; end
    end else if (m_res) begin
      e.ir = 1;
      if (ih) begin e.en = 1; e.fl = rd; m_res = 0; end
    end else begin
      e.ir = 1;
      if (dr || dw) m_mem = 1;
      else begin e.en = ih; e.fl = ih && rd; end
    end

    if (!e.en && !hw && !was_halted) m_stall++;
    if (e.fl) m_flush++;
    if (was_wait) begin
      m_wait++;
      if (m_wait >= TOUT_B) m_tout = 1;
    end
    if (!m_mem && !m_res && !m_halted) m_wait = 0;
  endtask

  // One clock of stimulus: drive both DUTs, record the expected response.
  task automatic step(input bit rst, ih, dh, dr, dw, rd, hw);
    exp_t e;
    @(posedge CLK);
    #1;
    RST = rst;
    ifa.ihit = ih; ifa.dhit = dh; ifa.dREN_m = dr; ifa.dWEN_m = dw;
    ifa.redirect = rd; ifa.halt_wb = hw;
    ifb.ihit = ih; ifb.dhit = dh; ifb.dREN_m = dr; ifb.dWEN_m = dw;
    ifb.redirect = rd; ifb.halt_wb = hw;
    model(rst, ih, dh, dr, dw, rd, hw, e);
    sb.push_back(e);
  endtask

  // -------------------------------------------------------------------------
  // Monitor: every cycle the DUTs present a full output set.
  // -------------------------------------------------------------------------
  exp_t got;
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("enable_a", int'(ifa.enable), int'(got.en));
      check("flush_a",  int'(ifa.flush),  int'(got.fl));
      check("iREN_a",   int'(ifa.iREN),   int'(got.ir));
      check("dREN_a",   int'(ifa.dREN),   int'(got.dr));
      check("dWEN_a",   int'(ifa.dWEN),   int'(got.dw));
      check("halt_a",   int'(halt_a),     int'(got.hl));
      check("timeout_a", int'(timeout_a), 0);
      check("stall_cnt_a", int'(stall_a), sat(got.stall, 65535));
      check("flush_cnt_a", int'(flush_a), sat(got.flush, 65535));
      check("enable_b", int'(ifb.enable), int'(got.en));
      check("flush_b",  int'(ifb.flush),  int'(got.fl));
      check("iREN_b",   int'(ifb.iREN),   int'(got.ir));
      check("dREN_b",   int'(ifb.dREN),   int'(got.dr));
      check("dWEN_b",   int'(ifb.dWEN),   int'(got.dw));
      check("halt_b",   int'(halt_b),     int'(got.hl));
      check("timeout_b", int'(timeout_b), int'(got.to_b));
      check("stall_cnt_b", int'(stall_b), sat(got.stall, 15));
      check("flush_cnt_b", int'(flush_b), sat(got.flush, 15));
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    ifa.ihit = 0; ifa.dhit = 0; ifa.dREN_m = 0; ifa.dWEN_m = 0;
    ifa.redirect = 0; ifa.halt_wb = 0;
    ifb.ihit = 0; ifb.dhit = 0; ifb.dREN_m = 0; ifb.dWEN_m = 0;
    ifb.redirect = 0; ifb.halt_wb = 0;

    //        rst ih dh dr dw rd hw
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1);

    // Straight-line fetch with a one-cycle redirect pulse.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, i == 2, 0);

    // Load: IFETCH request, dhit on 3rd DMEM cycle, ihit in first RESUME cycle.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Redirect held through a store stall, honoured when RESUME completes.
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Halt while in DMEM, then toggle hits; everything stays frozen.
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(0, i[0], ~i[0], 1, 0, 0, i < 2);

    // Watchdog: store never completes, then completes late, then RST.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // RST mid-DMEM, then a 20-cycle fetch stall to saturate the 4-bit counter.
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    #1;
    check("sat_stall_cnt_b", int'(stall_b), 15);
    check("stall_cnt_a_20", int'(stall_a), 20);

    // Randomised traffic with occasional resets and halts.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 60) == 0,
           ($urandom % 2) == 0,
           ($urandom % 3) == 0,
           ($urandom % 4) == 0,
           ($urandom % 5) == 0,
           ($urandom % 4) == 0,
           ($urandom % 90) == 0);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
